// File: rtl/turn_timer_ctrl.sv
// Turn/score/winner sequencer for the two-player card-match HUD.
// Every output is a flop; digits are BCD and drive the seven-segment decoders directly.
module turn_timer_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int TURN_SECS = 15,
  parameter int PAIRS     = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       match_valid,
  input  logic       match_hit,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [3:0] timer_tens,
  output logic [3:0] timer_ones,
  output logic [3:0] player,
  output logic [3:0] winner,
  output logic       game_over,
  output logic       timeout
);

  localparam int              PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [3:0]      TENS_INIT = 4'(TURN_SECS / 10);
  localparam logic [3:0]      ONES_INIT = 4'(TURN_SECS % 10);
  localparam logic [4:0]      PAIRS_W   = 5'(PAIRS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    p1_q, p1_d, p2_q, p2_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic [3:0]    player_q, player_d, winner_q, winner_d;
  logic          timeout_q, timeout_d;
  logic          tick, reload, restart;
  logic [3:0]    other_player;

  assign tick         = (state_q == S_PLAY) && (pre_q == PRE_MAX);
  assign other_player = (player_q == 4'd1) ? 4'd2 : 4'd1;

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    player_d  = player_q;
    winner_d  = winner_q;
    timeout_d = 1'b0;
    reload    = 1'b0;
    restart   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLAY;
          restart = 1'b1;
        end
      end
      S_PLAY: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        // A match outranks a coincident tick, so a pair found in the last second never times out
        if (start) begin
          restart = 1'b1;
        end else if (match_valid && match_hit) begin
          if (player_q == 4'd1) p1_d = p1_q + 4'd1;
          else                  p2_d = p2_q + 4'd1;
          reload = 1'b1;
          if (({1'b0, p1_d} + {1'b0, p2_d}) == PAIRS_W) begin
            state_d = S_OVER;
            if (p1_d > p2_d)      winner_d = 4'd1;
            else if (p2_d > p1_d) winner_d = 4'd2;
            else                  winner_d = 4'd0;
          end
        end else if (match_valid) begin
          player_d = other_player;
          reload   = 1'b1;
        end else if (tick) begin
          if (tens_q == 4'd0 && ones_q == 4'd1) begin
            timeout_d = 1'b1;
            player_d  = other_player;
            reload    = 1'b1;
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d  = S_PLAY;
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      player_d = 4'd1;
      winner_d = 4'd0;
      reload   = 1'b1;
    end
    if (reload) begin
      tens_d = TENS_INIT;
      ones_d = ONES_INIT;
      pre_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      p1_q      <= 4'd0;
      p2_q      <= 4'd0;
      tens_q    <= TENS_INIT;
      ones_q    <= ONES_INIT;
      player_q  <= 4'd1;
      winner_q  <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      player_q  <= player_d;
      winner_q  <= winner_d;
      timeout_q <= timeout_d;
    end
  end

  assign score_p1   = p1_q;
  assign score_p2   = p2_q;
  assign timer_tens = tens_q;
  assign timer_ones = ones_q;
  assign player     = player_q;
  assign winner     = winner_q;
  assign game_over  = (state_q == S_OVER);
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Directed bench for turn_timer_ctrl: a small-timing instance (4 Hz, 3 s, 2 pairs)
// and a two-digit instance (2 Hz, 15 s, 8 pairs) sharing the same stimulus.
module tb_turn_timer_ctrl;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic match_valid = 1'b0;
  logic match_hit = 1'b0;

  logic [3:0] a_p1, a_p2, a_tt, a_to, a_pl, a_win;
  logic       a_go, a_tmo;
  logic [3:0] b_p1, b_p2, b_tt, b_to, b_pl, b_win;
  logic       b_go, b_tmo;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  turn_timer_ctrl #(.CLK_HZ(4), .TURN_SECS(3), .PAIRS(2)) dut_a (
    .clock(clock), .resetn(resetn), .start(start),
    .match_valid(match_valid), .match_hit(match_hit),
    .score_p1(a_p1), .score_p2(a_p2), .timer_tens(a_tt), .timer_ones(a_to),
    .player(a_pl), .winner(a_win), .game_over(a_go), .timeout(a_tmo)
  );

  turn_timer_ctrl #(.CLK_HZ(2), .TURN_SECS(15), .PAIRS(8)) dut_b (
    .clock(clock), .resetn(resetn), .start(start),
    .match_valid(match_valid), .match_hit(match_hit),
    .score_p1(b_p1), .score_p2(b_p2), .timer_tens(b_tt), .timer_ones(b_to),
    .player(b_pl), .winner(b_win), .game_over(b_go), .timeout(b_tmo)
  );

  // Packed snapshot: {p1, p2, tens, ones, player, winner, game_over, timeout}
  function automatic logic [25:0] snap_a();
    return {a_p1, a_p2, a_tt, a_to, a_pl, a_win, a_go, a_tmo};
  endfunction

  function automatic logic [25:0] snap_b();
    return {b_p1, b_p2, b_tt, b_to, b_pl, b_win, b_go, b_tmo};
  endfunction

  function automatic logic [25:0] mk(input int p1, input int p2, input int tt, input int to,
                                     input int pl, input int w, input bit go, input bit tmo);
    return {4'(p1), 4'(p2), 4'(tt), 4'(to), 4'(pl), 4'(w), go, tmo};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_match(input bit hit);
    match_valid = 1'b1;
    match_hit   = hit;
    step(1);
    match_valid = 1'b0;
    match_hit   = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] exp;
    resetn = 1'b0;
    step(2);
    exp = mk(0, 0, 0, 3, 1, 0, 0, 0);
    checks++;
    if (snap_a() !== exp) begin
      errors++;
      $display("FAIL reset_a actual %h required %h", snap_a(), exp);
    end
    exp = mk(0, 0, 1, 5, 1, 0, 0, 0);
    checks++;
    if (snap_b() !== exp) begin
      errors++;
      $display("FAIL reset_b actual %h required %h", snap_b(), exp);
    end
    resetn = 1'b1;
    step(3);
    checks++;
    if (snap_a() !== mk(0, 0, 0, 3, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL idle_hold actual %h required %h", snap_a(), mk(0, 0, 0, 3, 1, 0, 0, 0));
    end
  endtask

  task automatic test_countdown();
    int pulses;
    pulse_start();
    checks++;
    if (snap_a() !== mk(0, 0, 0, 3, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL start_a actual %h required %h", snap_a(), mk(0, 0, 0, 3, 1, 0, 0, 0));
    end
    step(3);
    checks++;
    if ({a_tt, a_to} !== 8'h03) begin
      errors++;
      $display("FAIL pre_tick actual %h required 03", {a_tt, a_to});
    end
    step(1);
    checks++;
    if ({a_tt, a_to} !== 8'h02) begin
      errors++;
      $display("FAIL tick4 actual %h required 02", {a_tt, a_to});
    end
    step(4);
    checks++;
    if ({a_tt, a_to, a_tmo} !== 9'h002) begin
      errors++;
      $display("FAIL tick8 actual %h required 002", {a_tt, a_to, a_tmo});
    end
    step(3);
    checks++;
    if (a_tmo !== 1'b0) begin
      errors++;
      $display("FAIL early_timeout actual %b required 0", a_tmo);
    end
    step(1);
    checks++;
    if (snap_a() !== mk(0, 0, 0, 3, 2, 0, 0, 1)) begin
      errors++;
      $display("FAIL timeout_a actual %h required %h", snap_a(), mk(0, 0, 0, 3, 2, 0, 0, 1));
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (a_tmo === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL timeout_width actual %0d extra pulses required 0", pulses);
    end
  endtask

  task automatic test_hit_miss();
    pulse_start();
    step(2);
    pulse_match(1'b1);
    checks++;
    if (snap_a() !== mk(1, 0, 0, 3, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL hit_a actual %h required %h", snap_a(), mk(1, 0, 0, 3, 1, 0, 0, 0));
    end
    step(3);
    checks++;
    if ({a_tt, a_to} !== 8'h03) begin
      errors++;
      $display("FAIL hit_prescaler_restart actual %h required 03", {a_tt, a_to});
    end
    step(1);
    checks++;
    if ({a_tt, a_to} !== 8'h02) begin
      errors++;
      $display("FAIL hit_next_tick actual %h required 02", {a_tt, a_to});
    end
    pulse_match(1'b0);
    checks++;
    if (snap_a() !== mk(1, 0, 0, 3, 2, 0, 0, 0)) begin
      errors++;
      $display("FAIL miss_a actual %h required %h", snap_a(), mk(1, 0, 0, 3, 2, 0, 0, 0));
    end
  endtask

  task automatic test_game_over();
    pulse_start();
    pulse_match(1'b1);
    pulse_match(1'b0);
    pulse_match(1'b1);
    checks++;
    if (snap_a() !== mk(1, 1, 0, 3, 2, 0, 1, 0)) begin
      errors++;
      $display("FAIL over_tie actual %h required %h", snap_a(), mk(1, 1, 0, 3, 2, 0, 1, 0));
    end
    pulse_match(1'b1);
    pulse_match(1'b0);
    step(10);
    checks++;
    if (snap_a() !== mk(1, 1, 0, 3, 2, 0, 1, 0)) begin
      errors++;
      $display("FAIL over_hold actual %h required %h", snap_a(), mk(1, 1, 0, 3, 2, 0, 1, 0));
    end
    pulse_start();
    checks++;
    if (snap_a() !== mk(0, 0, 0, 3, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL over_restart actual %h required %h", snap_a(), mk(0, 0, 0, 3, 1, 0, 0, 0));
    end
    pulse_match(1'b1);
    pulse_match(1'b1);
    checks++;
    if (snap_a() !== mk(2, 0, 0, 3, 1, 1, 1, 0)) begin
      errors++;
      $display("FAIL win_p1 actual %h required %h", snap_a(), mk(2, 0, 0, 3, 1, 1, 1, 0));
    end
    pulse_start();
    pulse_match(1'b0);
    pulse_match(1'b1);
    pulse_match(1'b1);
    checks++;
    if (snap_a() !== mk(0, 2, 0, 3, 2, 2, 1, 0)) begin
      errors++;
      $display("FAIL win_p2 actual %h required %h", snap_a(), mk(0, 2, 0, 3, 2, 2, 1, 0));
    end
  endtask

  task automatic test_match_on_tick();
    pulse_start();
    step(11);
    checks++;
    if ({a_tt, a_to} !== 8'h01) begin
      errors++;
      $display("FAIL pre_collision_timer actual %h required 01", {a_tt, a_to});
    end
    pulse_match(1'b1);
    checks++;
    if (snap_a() !== mk(1, 0, 0, 3, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL match_beats_tick actual %h required %h", snap_a(), mk(1, 0, 0, 3, 1, 0, 0, 0));
    end
    step(1);
    checks++;
    if (a_tmo !== 1'b0) begin
      errors++;
      $display("FAIL collision_late_timeout actual %b required 0", a_tmo);
    end
  endtask

  task automatic test_bcd_borrow();
    pulse_start();
    checks++;
    if ({b_tt, b_to} !== 8'h15) begin
      errors++;
      $display("FAIL b_start actual %h required 15", {b_tt, b_to});
    end
    step(10);
    checks++;
    if ({b_tt, b_to} !== 8'h10) begin
      errors++;
      $display("FAIL b_ten actual %h required 10", {b_tt, b_to});
    end
    step(2);
    checks++;
    if ({b_tt, b_to} !== 8'h09) begin
      errors++;
      $display("FAIL b_borrow actual %h required 09", {b_tt, b_to});
    end
    step(17);
    checks++;
    if ({b_tt, b_to, b_tmo} !== 9'h002) begin
      errors++;
      $display("FAIL b_last_second actual %h required 002", {b_tt, b_to, b_tmo});
    end
    step(1);
    checks++;
    if (snap_b() !== mk(0, 0, 1, 5, 2, 0, 0, 1)) begin
      errors++;
      $display("FAIL b_timeout actual %h required %h", snap_b(), mk(0, 0, 1, 5, 2, 0, 0, 1));
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    pulse_match(1'b1);
    pulse_match(1'b0);
    step(5);
    checks++;
    if (snap_a() !== mk(1, 0, 0, 2, 2, 0, 0, 0)) begin
      errors++;
      $display("FAIL pre_reset actual %h required %h", snap_a(), mk(1, 0, 0, 2, 2, 0, 0, 0));
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (snap_a() !== mk(0, 0, 0, 3, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL async_reset actual %h required %h", snap_a(), mk(0, 0, 0, 3, 1, 0, 0, 0));
    end
    start = 1'b1;
    step(3);
    start = 1'b0;
    resetn = 1'b1;
    step(10);
    checks++;
    if (snap_a() !== mk(0, 0, 0, 3, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL start_during_reset actual %h required %h", snap_a(), mk(0, 0, 0, 3, 1, 0, 0, 0));
    end
    pulse_match(1'b1);
    checks++;
    if (a_p1 !== 4'd0) begin
      errors++;
      $display("FAIL idle_match_ignored actual %0d required 0", a_p1);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_countdown();
    test_hit_miss();
    test_game_over();
    test_match_on_tick();
    test_bcd_borrow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_timer_ctrl.md
Name: turn_timer_ctrl

Overview:
Game sequencer for the two-player card-match HUD. It owns the player turn, the per-turn countdown, both scores and the winner. Its digit outputs feed the HUD seven-segment decoders directly: scores on HEX0/HEX1, timer on HEX3/HEX2, active player on HEX4, winner on HEX6. Match results arrive as single-cycle pulses from the board/compare logic.

Parameters:
CLK_HZ, 50000000, clock cycles per one-second tick. Must be ≥2.
TURN_SECS, 15, turn length in seconds. Range 1..99.
PAIRS, 8, total card pairs on the board. Range 1..9, so each score fits in one BCD digit.

Ports:
clock  input  1  system clock. All state changes on the rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  single-cycle pulse that starts or restarts a game.
match_valid  input  1  single-cycle pulse: the current player has flipped two cards.
match_hit  input  1  qualifies match_valid: 1 means the pair matched, 0 means a miss.
score_p1  output  4  BCD score of player 1.
score_p2  output  4  BCD score of player 2.
timer_tens  output  4  BCD tens digit of the remaining turn time.
timer_ones  output  4  BCD ones digit of the remaining turn time.
player  output  4  active player, 4'd1 or 4'd2.
winner  output  4  4'd0 = none or tie; 4'd1 or 4'd2 = that player won.
game_over  output  1  high while in state OVER.
timeout  output  1  single-cycle pulse when a turn expires.

Behaviour:
- Reset (asynchronous, while resetn = 0):
  - State IDLE; scores 0; player 1; timer = TURN_SECS in BCD (15 gives tens 1, ones 5).
  - winner 0, game_over 0, timeout 0, prescaler 0.
- States: IDLE, PLAY, OVER. All outputs are registered; there is no combinational path from inputs to outputs.
- Prescaler: counts 0..CLK_HZ-1 in PLAY only.
  - tick = 1 in the cycle where prescaler == CLK_HZ-1; the prescaler then wraps to 0.
  - The prescaler holds its value in IDLE and OVER.
- "Reload" means: timer := TURN_SECS and prescaler := 0.
- IDLE:
  - match_valid is ignored.
  - On start: go to PLAY, reload.
- PLAY, evaluated in priority order each cycle:
  1. start: restart the game. Scores := 0, player := 1, winner := 0, reload; stay in PLAY.
  2. match_valid with match_hit = 1:
     - The current player's score increments and the same player keeps the turn; reload.
     - If the new p1+p2 == PAIRS: go to OVER and set winner (higher score, or 0 on a tie). The timer freezes at its reloaded value.
  3. match_valid with match_hit = 0: player toggles 1↔2; reload.
  4. tick:
     - If timer == 1: timeout = 1 for this cycle, player toggles, reload.
     - Otherwise: BCD decrement (ones == 0 gives ones := 9, tens := tens-1; else ones := ones-1).
     - The display therefore shows TURN_SECS down to 1, and 0 is never shown.
- If match_valid and tick occur in the same cycle, match_valid wins. No timeout pulse; the timer reloads.
- timeout is high only in the single cycle described in rule 4; it is 0 at all other times.
- OVER:
  - game_over = 1. Scores, player, winner and timer hold.
  - match_valid and tick are ignored.
  - start behaves exactly as a restart from PLAY: go to PLAY with game_over = 0.
- Reset mid-game (resetn asserted in any state): immediately returns every register to its reset value.
- Scores never exceed PAIRS. No wrap logic is required.

Test Plan:
Use CLK_HZ=4, TURN_SECS=3, PAIRS=2 unless stated.
1. Reset, then start → player=1, timer=0/3. After 4 cycles timer=0/2; after 8 cycles 0/1. At 12 cycles timeout pulses once, player=2, timer=0/3.
2. start; match_valid+hit → score_p1=1, player=1, timer=0/3, prescaler restarts (next decrement is 4 cycles later). Then match_valid with hit=0 → player=2.
3. start; P1 hits once, P1 misses, P2 hits once → p1+p2=2, game_over=1, winner=0 (tie). Further match_valid pulses change nothing. start → scores 0/0, player 1, game_over 0.
4. With timer=0/1, drive match_valid+hit in the exact tick cycle → no timeout, score_p1 increments, player stays 1, timer=0/3.
5. TURN_SECS=15, CLK_HZ=2: start → timer 1/5; after 12 cycles timer=0/9 (BCD borrow from tens). After 30 cycles timeout pulses.
6. Pull resetn low mid-PLAY, asynchronously between clock edges → all outputs return to reset values before the next clock edge. start is ignored while resetn = 0.
